// File: rtl/addsub_mp_serial.sv
// Slice-serial multi-precision ADD/ADC/SUB/SBC with ARM-style N/Z/C/V flags.
// One WIDTH-bit slice per clock, least-significant slice first.
module addsub_mp_serial #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic                     c_in,
  input  logic [WIDTH*WORDS-1:0]   a,
  input  logic [WIDTH*WORDS-1:0]   b,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH*WORDS-1:0]   s,
  output logic                     c_out,
  output logic                     v_out,
  output logic                     n_out,
  output logic                     z_out
);

  localparam int N  = WIDTH * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_r;
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic            sub_r;
  logic            carry_r;
  logic            zacc_r;
  logic [IW-1:0]   idx_r;

  logic [31:0]     base_s;
  logic [WIDTH-1:0] a_sl_s;
  logic [WIDTH-1:0] b_sl_s;
  logic [WIDTH:0]  sum_s;
  logic [WIDTH-1:0] r_s;
  logic            cy_s;
  logic            r_zero_s;
  logic [N-1:0]    slice_mask_s;

  // Operand registers shift right each slice, so the active slice is always the low WIDTH bits.
  assign base_s       = 32'(idx_r) * 32'(WIDTH);
  assign a_sl_s       = a_r[WIDTH-1:0];
  assign b_sl_s       = sub_r ? ~b_r[WIDTH-1:0] : b_r[WIDTH-1:0];
  assign sum_s        = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{WIDTH{1'b0}}, carry_r};
  assign r_s          = sum_s[WIDTH-1:0];
  assign cy_s         = sum_s[WIDTH];
  assign r_zero_s     = (r_s == {WIDTH{1'b0}});
  assign slice_mask_s = N'({WIDTH{1'b1}}) << base_s;

  // Control FSM, slice datapath and registered result/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= {N{1'b0}};
      c_out   <= 1'b0;
      v_out   <= 1'b0;
      n_out   <= 1'b0;
      z_out   <= 1'b0;
      a_r     <= {N{1'b0}};
      b_r     <= {N{1'b0}};
      sub_r   <= 1'b0;
      carry_r <= 1'b0;
      zacc_r  <= 1'b0;
      idx_r   <= {IW{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            sub_r   <= op[1];
            // ADD:0, ADC:c_in, SUB:1, SBC:c_in
            carry_r <= op[0] ? c_in : op[1];
            idx_r   <= {IW{1'b0}};
            zacc_r  <= 1'b1;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
          end
        end
        RUN: begin
          a_r     <= a_r >> WIDTH;
          b_r     <= b_r >> WIDTH;
          s       <= (s & ~slice_mask_s) | (N'(r_s) << base_s);
          carry_r <= cy_s;
          zacc_r  <= zacc_r & r_zero_s;
          idx_r   <= idx_r + IW'(1);
          if (idx_r == LAST) begin
            c_out   <= cy_s;
            z_out   <= zacc_r & r_zero_s;
            n_out   <= r_s[WIDTH-1];
            v_out   <= (a_sl_s[WIDTH-1] == b_sl_s[WIDTH-1]) & (r_s[WIDTH-1] != a_sl_s[WIDTH-1]);
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            busy    <= 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_mp_serial.sv
// Directed bench for addsub_mp_serial: WIDTH=8/WORDS=4 instance plus a default-parameter instance.
module tb_addsub_mp_serial;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic         c_in;
  logic [31:0]  a, b, s;
  logic         busy, done, c_out, v_out, n_out, z_out;

  logic         bstart;
  logic [1:0]   bop;
  logic         bc_in;
  logic [127:0] ba, bb, bs;
  logic         bbusy, bdone, bc, bv, bn, bz;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp5 [3];

  always #5 clk = ~clk;

  addsub_mp_serial #(.WIDTH(8), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .c_in(c_in), .a(a), .b(b),
    .busy(busy), .done(done), .s(s), .c_out(c_out), .v_out(v_out), .n_out(n_out), .z_out(z_out)
  );

  addsub_mp_serial dut_big (
    .clk(clk), .rst(rst), .start(bstart), .op(bop), .c_in(bc_in), .a(ba), .b(bb),
    .busy(bbusy), .done(bdone), .s(bs), .c_out(bc), .v_out(bv), .n_out(bn), .z_out(bz)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ef = {C, V, N, Z}
  task automatic run_op(input string tag, input logic [1:0] o, input logic ci,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] es, input logic [3:0] ef);
    int n = 0;
    @(negedge clk);
    op = o; c_in = ci; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, 128'(busy), 128'd1);
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'd4);
    chk({tag, "_s"}, 128'(s), 128'(es));
    chk({tag, "_cvnz"}, 128'({c_out, v_out, n_out, z_out}), 128'(ef));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 128'(done), 128'd0);
  endtask

  task automatic run_big(input string tag, input logic [1:0] o, input logic ci,
                         input logic [127:0] x, input logic [127:0] y,
                         input logic [127:0] es, input logic ec);
    int n = 0;
    @(negedge clk);
    bop = o; bc_in = ci; ba = x; bb = y; bstart = 1'b1;
    @(posedge clk); #1;
    bstart = 1'b0;
    while (!bdone && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'd4);
    chk({tag, "_s"}, bs, es);
    chk({tag, "_c"}, 128'(bc), 128'(ec));
  endtask

  initial begin
    int nd;
    int ecnt;
    int prev;
    logic [31:0] s1;

    rst = 1'b1; start = 1'b0; op = 2'b00; c_in = 1'b0; a = 32'd0; b = 32'd0;
    bstart = 1'b0; bop = 2'b00; bc_in = 1'b0; ba = 128'd0; bb = 128'd0;
    exp5[0] = 32'd123; exp5[1] = 32'd1001; exp5[2] = 32'd15;
    #12;
    chk("reset_outputs", 128'({busy, done, c_out, v_out, n_out, z_out}), 128'd0);
    chk("reset_s", 128'(s), 128'd0);
    chk("reset_big", {bs[125:0], bbusy, bdone}, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Scenario 1
    run_op("add",  2'b00, 1'b0, 32'd82347156, 32'd9483, 32'd82356639, 4'b0000);
    run_op("adc",  2'b01, 1'b1, 32'd82347156, 32'd9483, 32'd82356640, 4'b0000);
    run_op("sub",  2'b10, 1'b1, 32'd82347156, 32'd9483, 32'd82337673, 4'b1000);
    run_op("sbc",  2'b11, 1'b0, 32'd82347156, 32'd9483, 32'd82337672, 4'b1000);
    // Scenario 1 at default parameters
    run_big("big_add", 2'b00, 1'b0, 128'd82347156, 128'd9483, 128'd82356639, 1'b0);
    run_big("big_adc", 2'b01, 1'b1, 128'd82347156, 128'd9483, 128'd82356640, 1'b0);
    run_big("big_sub", 2'b10, 1'b0, 128'd82347156, 128'd9483, 128'd82337673, 1'b1);
    run_big("big_sbc", 2'b11, 1'b0, 128'd82347156, 128'd9483, 128'd82337672, 1'b1);
    // Scenario 2
    run_op("sub_neg", 2'b10, 1'b0, 32'd9483, 32'd82347156, 32'd4212629623, 4'b0010);
    run_op("sbc_neg", 2'b11, 1'b1, 32'd9483, 32'd82347156, 32'd4212629623, 4'b0010);
    // Scenario 3
    run_op("add_ripple", 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1001);
    run_op("sub_equal",  2'b10, 1'b0, 32'd5, 32'd5, 32'd0, 4'b1001);
    // Scenario 4
    run_op("add_ovf", 2'b00, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0110);
    run_op("sub_ovf", 2'b10, 1'b0, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b1100);

    // Scenario 5a: second start mid-operation is ignored
    @(negedge clk);
    op = 2'b00; a = 32'd1000; b = 32'd234; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    op = 2'b10; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0; s1 = 32'd0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (nd == 1) s1 = s;
      end
    end
    chk("ignore_start_done_count", 128'(nd), 128'd1);
    chk("ignore_start_s", 128'(s1), 128'd1234);

    // Scenario 5b: start held high, new operands picked up on each done cycle
    @(negedge clk);
    op = 2'b00; a = 32'd100; b = 32'd23; start = 1'b1;
    nd = 0; ecnt = 0; prev = 0;
    while (nd < 3 && ecnt < 40) begin
      @(posedge clk); #1;
      ecnt++;
      if (done) begin
        chk("held_start_s", 128'(s), 128'(exp5[nd]));
        if (nd > 0) chk("held_start_period", 128'(ecnt - prev), 128'd5);
        else        chk("held_start_first", 128'(ecnt), 128'd5);
        prev = ecnt;
        nd++;
        @(negedge clk);
        if (nd == 1) begin a = 32'd1000; b = 32'd1; end
        else if (nd == 2) begin a = 32'd7; b = 32'd8; end
        else start = 1'b0;
      end
    end
    chk("held_start_done_count", 128'(nd), 128'd3);
    @(posedge clk); #1;
    chk("held_start_idle_after", 128'(busy), 128'd0);

    // Scenario 6: asynchronous reset mid-operation
    @(negedge clk);
    op = 2'b00; a = 32'h1111_1111; b = 32'h2222_2222; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    chk("pre_reset_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    chk("midop_reset_ctrl", 128'({busy, done, c_out, v_out, n_out, z_out}), 128'd0);
    chk("midop_reset_s", 128'(s), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("no_done_after_reset", 128'(nd), 128'd0);
    run_op("post_reset_add", 2'b00, 1'b0, 32'd3, 32'd4, 32'd7, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/addsub_mp_serial.md
# addsub_mp_serial

Parametrised multi-precision adder/subtractor. It processes two `WIDTH*WORDS`-bit operands one `WIDTH`-bit slice per clock, least-significant slice first. It supports ADD, ADC, SUB and SBC and produces ARM-style N/Z/C/V flags. It is the sequential, width-scalable successor to the 32-bit combinational ADD/ADCS/SUBS unit. It sits in the ALU datapath wherever operands exceed one native word or a single-cycle wide carry chain would not meet timing.

## Interface
Parameters:
- `WIDTH`, 32, slice width in bits processed per cycle (≥1)
- `WORDS`, 4, number of slices; total operand width `N = WIDTH*WORDS` (≥1)

Ports:
- `clk`  in  1  single clock, rising-edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request an operation; sampled at a rising edge when `busy`=0
- `op`  in  2  00 ADD, 01 ADC, 10 SUB, 11 SBC
- `c_in`  in  1  carry input for ADC/SBC (SBC: 1 = no borrow)
- `a`  in  N  operand A, captured on start
- `b`  in  N  operand B, captured on start
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse: `s` and the flags are valid
- `s`  out  N  result
- `c_out`  out  1  carry out of bit N-1 (SUB/SBC: 1 = no borrow)
- `v_out`  out  1  signed overflow
- `n_out`  out  1  `s[N-1]`
- `z_out`  out  1  `s == 0`

## Operation
- Internal state:
  - operand registers A/B
  - `op` register
  - carry register
  - slice index, width ceil(log2(WORDS)), minimum 1 bit
  - zero accumulator
  - `busy` flag
- Initial carry at capture:
  - ADD → 0
  - ADC → `c_in`
  - SUB → 1
  - SBC → `c_in`
- Effective B operand:
  - ADD/ADC: `b`
  - SUB/SBC: `~b`
- Per-slice computation:
  - `{cy, r} = A[k] + B'[k] + carry`, computed in WIDTH+1 bits
  - `s[k*WIDTH +: WIDTH] ← r`
  - `carry ← cy`
  - zero accumulator ANDed with `(r == 0)`
- States:
  - IDLE (`busy`=0): start → capture operands and `op`, load initial carry, index←0, zero-acc←1, enter RUN.
  - RUN (`busy`=1): compute slice `index` each edge; index increments.
  - On the slice where index = WORDS-1, at that same edge:
    - `c_out` ← cy
    - `z_out` ← zero-acc & (r==0)
    - `n_out` ← r[WIDTH-1]
    - `v_out` ← (A_msb == B'_msb) & (r_msb != A_msb)
    - `done` ← 1, `busy` ← 0, return to IDLE
- `start` while `busy`=1 is ignored; there is no queuing.
- `start` in the cycle `done`=1 is accepted (busy is already 0). `done` clears at that edge and the new operation begins.
- `s` is written slice-by-slice during RUN. `s` and the flags are guaranteed only from `done` until the edge after the next accepted start. Between operations the flags hold their last values.
- Operand inputs are don't-care except at the start edge.

## Timing
- Reset (async assert, any time): `busy`=0, `done`=0, `s`=0, all flags 0, index 0, FSM IDLE. An operation in flight is abandoned with no done pulse.
- Reset deassertion is synchronous to `clk`. `start` is not accepted while `rst`=1.
- Start accepted at edge E0 → slices computed at edges E1..E_WORDS → `done`=1 during the cycle after E_WORDS.
- Latency is WORDS+1 edges from the start edge to `done` observed. Throughput is one operation per WORDS+1 cycles; back-to-back starts are allowed on the `done` cycle.
- `busy`=1 for exactly WORDS cycles, from E0 to E_WORDS.
- WORDS=1: `busy` is high one cycle, and `done` is seen the cycle after.
- `done` is never high for two consecutive cycles unless a start is accepted on a done cycle and WORDS results in a new done later. Each done is exactly one cycle.

## Test plan
Run at `WIDTH`=8, `WORDS`=4 (N=32); also repeat scenario 1 at the defaults.
1. a=82347156, b=9483: ADD → s=82356639, C=0, V=0. ADC with `c_in`=1 → 82356640. SUB with `c_in` don't-care → 82337673, C=1. SBC with `c_in`=0 → 82337672. Each `done` arrives 5 edges after start.
2. a=9483, b=82347156, SUB → s=4212629623, C=0, N=1, V=0, Z=0. Same with SBC `c_in`=1 → same result.
3. Ripple across all slices: ADD a=0xFFFFFFFF, b=1 → s=0, C=1, Z=1, V=0, N=0. SUB a=5, b=5 → s=0, Z=1, C=1.
4. Overflow: ADD 0x7FFFFFFF+1 → s=0x80000000, V=1, N=1, C=0. SUB 0x80000000−1 → s=0x7FFFFFFF, V=1, C=1.
5. Handshake:
   - `start` pulsed again 2 cycles into an operation → ignored; a single `done` with the first result.
   - `start` held high continuously → one done every 5 cycles, each new operation capturing the operands present on its done cycle.
6. Reset mid-operation: assert `rst` asynchronously 2 cycles after start → `busy`, `done`, `s` and the flags go to 0 immediately, and no done follows. A fresh ADD 3+4 after release → s=7.
